// File: rtl/adder_sweep_ctrl.sv
// adder_sweep_ctrl
//   Sequencer for the N-bit adder / 7-segment datapath. Walks every operand
//   pair (a outer, b inner) through the adder. Each pair is held for DWELL
//   cycles so the HEX display can be read. On the last cycle of each dwell the
//   adder's returned sum is checked against a + b, and mismatches are counted.
//
// Ports
//   i_clk      system clock
//   i_rst_n    asynchronous active-low reset
//   i_start    start/restart pulse, honoured only in IDLE or DONE
//   i_pause    level; freezes operands and dwell counter while high
//   i_sum      N+1-bit sum returned by the adder (combinational from o_a/o_b)
//   o_a, o_b   operands driven to the adder
//   o_step     one-cycle pulse whenever a new pair is applied
//   o_busy     high while sweeping (SHOW)
//   o_done     high once the sweep has finished (DONE)
//   o_err      sticky mismatch flag
//   o_err_cnt  saturating mismatch count
module adder_sweep_ctrl #(
  parameter int unsigned N     = 3,
  parameter int unsigned DWELL = 25_000_000,
  parameter int unsigned ERRW  = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_pause,
  input  logic [N:0]      i_sum,
  output logic [N-1:0]    o_a,
  output logic [N-1:0]    o_b,
  output logic            o_step,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err,
  output logic [ERRW-1:0] o_err_cnt
);

  localparam int unsigned   CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    DONE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic            r_step;
  logic            r_busy;
  logic            r_done;
  logic            r_err;
  logic [ERRW-1:0] r_err_cnt;

  logic [N:0]      w_expect;
  logic            w_mismatch;
  logic            w_at_last;
  logic            w_a_max;
  logic            w_b_max;

  // Expected sum is computed one bit wider than the operands so the carry
  // out of the top bit is part of the check.
  always_comb begin
    w_expect   = {1'b0, r_a} + {1'b0, r_b};
    w_mismatch = (i_sum != w_expect);
    w_at_last  = (r_cnt == LAST);
    w_a_max    = (r_a == '1);
    w_b_max    = (r_b == '1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_step    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_step <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          // Restart from DONE behaves exactly like a first start from IDLE.
          if (i_start) begin
            r_state   <= SHOW;
            r_cnt     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_step    <= 1'b1;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
          end
        end
        SHOW: begin
          // Pause freezes everything, including a pending compare on the
          // last dwell cycle; it runs once the pause is released.
          if (!i_pause) begin
            if (w_at_last) begin
              if (w_mismatch) begin
                r_err <= 1'b1;
                if (r_err_cnt != '1) begin
                  r_err_cnt <= r_err_cnt + ERRW'(1);
                end
              end
              r_cnt <= '0;
              if (!w_b_max) begin
                r_b    <= r_b + N'(1);
                r_step <= 1'b1;
              end else if (!w_a_max) begin
                r_a    <= r_a + N'(1);
                r_b    <= '0;
                r_step <= 1'b1;
              end else begin
                // Operands keep their final values while in DONE.
                r_state <= DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_a       = r_a;
  assign o_b       = r_b;
  assign o_step    = r_step;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_err     = r_err;
  assign o_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_adder_sweep_ctrl.sv
// Testbench for adder_sweep_ctrl (N=3, DWELL=4, ERRW=8) with a behavioural
// adder whose result can have one bit forced low.
module tb_adder_sweep_ctrl;

  localparam int N     = 3;
  localparam int DWELL = 4;
  localparam int ERRW  = 8;
  localparam int NP    = 1 << (2 * N);
  localparam int LIMIT = 1000;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            pause;
  logic [N:0]      sum;
  logic [N-1:0]    a;
  logic [N-1:0]    b;
  logic            step;
  logic            busy;
  logic            done;
  logic            err;
  logic [ERRW-1:0] err_cnt;

  logic            fault_en;
  int              fbit;
  logic [N:0]      mask;

  int total;
  int bad;

  bit pz [0:LIMIT-1];
  int sa [0:NP-1];
  int sb [0:NP-1];
  int st [0:NP-1];
  int est[0:NP-1];
  int edone;

  adder_sweep_ctrl #(
    .N    (N),
    .DWELL(DWELL),
    .ERRW (ERRW)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_pause  (pause),
    .i_sum    (sum),
    .o_a      (a),
    .o_b      (b),
    .o_step   (step),
    .o_busy   (busy),
    .o_done   (done),
    .o_err    (err),
    .o_err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mask = fault_en ? ((N+1)'(1) << fbit) : '0;
  assign sum  = ({1'b0, a} + {1'b0, b}) & ~mask;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Reference timing: every pair needs DWELL un-paused clock edges; the next
  // pair (or DONE) becomes visible right after the edge that completes it.
  task automatic model_times();
    int k;
    int u;
    k = 0;
    u = 0;
    edone = -2;
    est[0] = 0;
    for (int j = 0; j < LIMIT; j++) begin
      if (!pz[j]) u++;
      if (u == DWELL) begin
        u = 0;
        k++;
        if (k == NP) begin
          edone = j + 1;
          break;
        end
        est[k] = j + 1;
      end
    end
  endtask

  function automatic int model_errs(input int npairs);
    int e;
    int s;
    e = 0;
    for (int k = 0; k < npairs; k++) begin
      s = k / 8 + k % 8;
      if (fault_en && s[fbit]) e++;
    end
    return (e > 255) ? 255 : e;
  endfunction

  // One sweep: start (optionally with pause also high), drive pz[] as the
  // pause level for each following cycle, and pulse start at istart_at.
  task automatic run_sweep(input string name, input bit start_pause, input int istart_at);
    int nsteps;
    int done_j;
    model_times();
    @(negedge clk);
    start = 1'b1;
    pause = start_pause;
    @(negedge clk);
    start  = 1'b0;
    nsteps = 0;
    done_j = -1;
    chk({name, "_start_step"}, step, 1);
    chk({name, "_start_busy"}, busy, 1);
    chk({name, "_start_done"}, done, 0);
    chk({name, "_start_errcnt"}, err_cnt, 0);
    chk({name, "_start_err"}, err, 0);
    for (int j = 0; j < LIMIT; j++) begin
      if (step) begin
        if (nsteps < NP) begin
          sa[nsteps] = a;
          sb[nsteps] = b;
          st[nsteps] = j;
        end
        nsteps++;
      end
      if (done) begin
        done_j = j;
        break;
      end
      pause = pz[j];
      start = (j == istart_at);
      @(negedge clk);
    end
    pause = 1'b0;
    start = 1'b0;
    chk({name, "_done_latency"}, done_j, edone);
    chk({name, "_nsteps"}, nsteps, NP);
    for (int k = 0; k < NP && k < nsteps; k++) begin
      chk($sformatf("%s_pair%0d", name, k), sa[k] * 8 + sb[k], k);
      chk($sformatf("%s_time%0d", name, k), st[k], est[k]);
    end
    chk({name, "_errcnt"}, err_cnt, model_errs(NP));
    chk({name, "_err"}, err, (model_errs(NP) != 0) ? 1 : 0);
    chk({name, "_final_a"}, a, 7);
    chk({name, "_final_b"}, b, 7);
    chk({name, "_final_busy"}, busy, 0);
  endtask

  task automatic clear_pz();
    for (int j = 0; j < LIMIT; j++) pz[j] = 1'b0;
  endtask

  initial begin
    int pos;
    int len;
    int found;
    total    = 0;
    bad      = 0;
    start    = 1'b0;
    pause    = 1'b0;
    fault_en = 1'b0;
    fbit     = 0;
    rst_n    = 1'b1;
    clear_pz();

    // Reset state, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_flags", {step, busy, done, err}, 0);
    chk("rst_errcnt", err_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pause = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_pause_busy", busy, 0);
    chk("idle_pause_step", step, 0);
    pause = 1'b0;

    // Clean sweep: order, dwell and latency.
    run_sweep("clean", 1'b0, -1);

    // Faulty bit0 adder, 10-cycle pause mid-dwell at pair (2,5), stray start
    // during pair (3,3); restarted from DONE.
    fault_en = 1'b1;
    fbit     = 0;
    clear_pz();
    for (int j = 85; j < 95; j++) pz[j] = 1'b1;
    run_sweep("fault_pause", 1'b0, 120);

    // Randomised: fault bit, pause bursts, stray start, start with pause high.
    fbit = $urandom_range(0, N);
    clear_pz();
    for (int r = 0; r < 6; r++) begin
      pos = $urandom_range(0, 220);
      len = $urandom_range(1, 8);
      for (int j = pos; j < pos + len; j++) pz[j] = 1'b1;
    end
    run_sweep("random", 1'b1, $urandom_range(1, 200));

    // Reset mid-sweep at pair (4,1) with a faulty adder.
    fbit = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int j = 0; j < 400; j++) begin
      if (step && a == 3'd4 && b == 3'd1) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("rstmid_reached", found, 1);
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_errcnt_before", err_cnt, model_errs(33));
    rst_n = 1'b0;
    #1;
    chk("rstmid_a", a, 0);
    chk("rstmid_b", b, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_errcnt", err_cnt, 0);
    chk("rstmid_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstmid_idle_busy", busy, 0);
    chk("rstmid_idle_done", done, 0);

    fault_en = 1'b0;
    clear_pz();
    run_sweep("after_rst", 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
